// File: rtl/sync_burst_sequencer.sv
// sync_burst_sequencer
//
// Sequences a burst of frame-grabber-synchronised trigger pulses. A rising edge on
// start_signal arms a burst of cfg_shots shots. Each shot waits for a (synchronised)
// rising edge of fg_signal, waits cfg_delay cycles, then drives output_trigger high
// for cfg_len cycles. Configuration is latched on burst accept only.
//
// Optional build macro: SYNC_TIMEOUT_EN -- adds a WAIT_FG dwell limit of
// TIMEOUT_CYCLES cycles; on expiry the burst is dropped and timeout pulses.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   start_signal   level; rising edge requests a burst (synchronous to clock)
//   fg_signal      frame-grabber signal, asynchronous (3-flop synchroniser)
//   abort          synchronous cancel, highest priority
//   cfg_delay      fg edge to trigger delay in cycles
//   cfg_len        trigger high time in cycles (>= 1)
//   cfg_shots      shots per burst (>= 1)
//   output_trigger registered trigger output
//   busy           high from burst accept until done/abort/timeout
//   done           one-cycle pulse as the final shot's pulse ends
//   cfg_err        one-cycle pulse when a start is rejected
//   timeout        one-cycle pulse on WAIT_FG expiry (0 without the macro)
//   shot_cnt       shots completed in the current/last burst
//   missed_cnt     fg edges seen during DELAY/PULSE, saturating
module sync_burst_sequencer #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned SHOT_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_signal,
  input  logic              fg_signal,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [SHOT_W-1:0] cfg_shots,
  output logic              output_trigger,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              timeout,
  output logic [SHOT_W-1:0] shot_cnt,
  output logic [SHOT_W-1:0] missed_cnt
);

  if (CNT_W < 1 || SHOT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sync_burst_sequencer: CNT_W, SHOT_W and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {StIdle, StWaitFg, StDelay, StPulse, StDone} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    delay_q, delay_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [SHOT_W-1:0]   shots_q, shots_d;
  logic [SHOT_W-1:0]   shot_q, shot_d;
  logic [SHOT_W-1:0]   missed_q, missed_d;
  logic                trig_q, trig_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                sync1_q, sync2_q, sync3_q;
  logic                start_q;
  logic                fg_edge, start_edge;
  logic [SHOT_W-1:0]   shot_inc;
  logic [SHOT_W-1:0]   missed_inc;

  assign fg_edge    = sync2_q & ~sync3_q;
  assign start_edge = start_signal & ~start_q;
  assign shot_inc   = shot_q + SHOT_W'(1);
  // Saturate rather than wrap so a long overrun stays visible to the host.
  assign missed_inc = (&missed_q) ? missed_q : missed_q + SHOT_W'(1);

`ifdef SYNC_TIMEOUT_EN
  localparam logic [31:0] WaitLast = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wait_q, wait_d;
  logic        to_q, to_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    len_d    = len_q;
    shots_d  = shots_q;
    shot_d   = shot_q;
    missed_d = missed_q;
    trig_d   = trig_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef SYNC_TIMEOUT_EN
    wait_d   = wait_q;
    to_d     = 1'b0;
`endif

    if (abort) begin
      // Abort beats everything, including a start edge in the same cycle.
      state_d = StIdle;
      trig_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            if (cfg_shots == '0 || cfg_len == '0) begin
              err_d = 1'b1;
            end else begin
              delay_d  = cfg_delay;
              len_d    = cfg_len;
              shots_d  = cfg_shots;
              shot_d   = '0;
              missed_d = '0;
              busy_d   = 1'b1;
              state_d  = StWaitFg;
`ifdef SYNC_TIMEOUT_EN
              wait_d   = '0;
`endif
            end
          end
        end
        StWaitFg: begin
          if (fg_edge) begin
            state_d = StDelay;
            cnt_d   = '0;
          end
`ifdef SYNC_TIMEOUT_EN
          else if (wait_q == WaitLast) begin
            to_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            wait_d = wait_q + 32'd1;
          end
`endif
        end
        StDelay: begin
          if (fg_edge) missed_d = missed_inc;
          if (cnt_q == delay_q) begin
            state_d = StPulse;
            cnt_d   = '0;
            trig_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StPulse: begin
          // An fg edge here is missed even on the cycle we re-arm; a fresh edge is needed.
          if (fg_edge) missed_d = missed_inc;
          if (cnt_q == len_q - CNT_W'(1)) begin
            trig_d = 1'b0;
            shot_d = shot_inc;
            cnt_d  = '0;
            if (shot_inc == shots_q) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StWaitFg;
`ifdef SYNC_TIMEOUT_EN
              wait_d  = '0;
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          trig_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      delay_q  <= '0;
      len_q    <= '0;
      shots_q  <= '0;
      shot_q   <= '0;
      missed_q <= '0;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
      len_q    <= len_d;
      shots_q  <= shots_d;
      shot_q   <= shot_d;
      missed_q <= missed_d;
      trig_q   <= trig_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sync1_q  <= fg_signal;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      start_q  <= start_signal;
    end
  end

`ifdef SYNC_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
      to_q   <= 1'b0;
    end else begin
      wait_q <= wait_d;
      to_q   <= to_d;
    end
  end
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign output_trigger = trig_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign cfg_err        = err_q;
  assign shot_cnt       = shot_q;
  assign missed_cnt     = missed_q;

endmodule

// File: tb/tb_sync_burst_sequencer.sv
// Directed bench for sync_burst_sequencer: single shot, burst, overrun, config error,
// abort, asynchronous reset and WAIT_FG timeout (behaviour depends on SYNC_TIMEOUT_EN).
module tb_sync_burst_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_signal;
  logic        fg_signal;
  logic        abort;
  logic [31:0] cfg_delay;
  logic [31:0] cfg_len;
  logic [15:0] cfg_shots;
  logic        output_trigger;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        timeout;
  logic [15:0] shot_cnt;
  logic [15:0] missed_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the last run() window; indices count ticks from 1.
  int rises[$];
  int dones[$];
  int high_cnt;
  int err_cnt;

  sync_burst_sequencer #(
    .CNT_W         (32),
    .SHOT_W        (16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_signal  (start_signal),
    .fg_signal     (fg_signal),
    .abort         (abort),
    .cfg_delay     (cfg_delay),
    .cfg_len       (cfg_len),
    .cfg_shots     (cfg_shots),
    .output_trigger(output_trigger),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .timeout       (timeout),
    .shot_cnt      (shot_cnt),
    .missed_cnt    (missed_cnt)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_burst(input int d, input int l, input int s);
    cfg_delay    = d;
    cfg_len      = l;
    cfg_shots    = 16'(s);
    start_signal = 1'b1;
    tick();
    start_signal = 1'b0;
  endtask

  // Drives `count` 3-cycle fg pulses starting at tick `first`, `period` ticks apart,
  // and records trigger rises, high time, done pulses and cfg_err pulses.
  task automatic run(input int n, input int first, input int period, input int count);
    logic f;
    logic prev;
    rises.delete();
    dones.delete();
    high_cnt = 0;
    err_cnt  = 0;
    prev     = output_trigger;
    for (int i = 1; i <= n; i++) begin
      f = 1'b0;
      for (int j = 0; j < count; j++)
        if (i >= first + j * period && i < first + j * period + 3) f = 1'b1;
      fg_signal = f;
      tick();
      if (output_trigger && !prev) rises.push_back(i);
      if (output_trigger) high_cnt++;
      if (done) dones.push_back(i);
      if (cfg_err) err_cnt++;
      prev = output_trigger;
    end
    fg_signal = 1'b0;
  endtask

  initial begin
    int to_at;
    reset        = 1'b0;
    start_signal = 1'b0;
    fg_signal    = 1'b0;
    abort        = 1'b0;
    cfg_delay    = '0;
    cfg_len      = '0;
    cfg_shots    = '0;
    tick();
    tick();
    check_eq("rst_trigger", 32'(output_trigger), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_cfg_err", 32'(cfg_err), 0);
    check_eq("rst_timeout", 32'(timeout), 0);
    check_eq("rst_shot_cnt", 32'(shot_cnt), 0);
    check_eq("rst_missed_cnt", 32'(missed_cnt), 0);
    reset = 1'b1;
    tick();

    // Single shot: fg sampled at tick 1 -> trigger ticks 14..18, done at 19.
    start_burst(10, 5, 1);
    check_eq("single_busy_accept", 32'(busy), 1);
    run(30, 1, 0, 1);
    check_eq("single_rise_cnt", rises.size(), 1);
    check_eq("single_rise_at", rises[0], 14);
    check_eq("single_high", high_cnt, 5);
    check_eq("single_done_cnt", dones.size(), 1);
    check_eq("single_done_at", dones[0], 19);
    check_eq("single_shot_cnt", 32'(shot_cnt), 1);
    check_eq("single_busy_end", 32'(busy), 0);

    // Burst of three, delay 0: triggers at fg+3.
    start_burst(0, 2, 3);
    run(60, 1, 20, 3);
    check_eq("burst_rise_cnt", rises.size(), 3);
    check_eq("burst_rise0", rises[0], 4);
    check_eq("burst_rise1", rises[1], 24);
    check_eq("burst_rise2", rises[2], 44);
    check_eq("burst_high", high_cnt, 6);
    check_eq("burst_done_cnt", dones.size(), 1);
    check_eq("burst_done_at", dones[0], 46);
    check_eq("burst_shot_cnt", 32'(shot_cnt), 3);
    check_eq("burst_missed_cnt", 32'(missed_cnt), 0);
    check_eq("burst_busy_end", 32'(busy), 0);

    // Overrun: second fg during DELAY is missed; sequencer then waits for a fresh one.
    start_burst(50, 5, 2);
    run(80, 1, 10, 2);
    check_eq("ovr_rise_cnt", rises.size(), 1);
    check_eq("ovr_rise_at", rises[0], 54);
    check_eq("ovr_missed_cnt", 32'(missed_cnt), 1);
    check_eq("ovr_shot_cnt", 32'(shot_cnt), 1);
    check_eq("ovr_busy_wait", 32'(busy), 1);
    check_eq("ovr_no_done", dones.size(), 0);
    run(70, 1, 0, 1);
    check_eq("ovr2_rise_at", rises[0], 54);
    check_eq("ovr2_done_at", dones[0], 59);
    check_eq("ovr2_shot_cnt", 32'(shot_cnt), 2);
    check_eq("ovr2_missed_hold", 32'(missed_cnt), 1);

    // Config errors: shots=0 then len=0; counters from the last burst must hold.
    start_burst(3, 5, 0);
    check_eq("err_shots_pulse", 32'(cfg_err), 1);
    check_eq("err_shots_busy", 32'(busy), 0);
    tick();
    check_eq("err_shots_one_cycle", 32'(cfg_err), 0);
    start_burst(3, 0, 1);
    check_eq("err_len_pulse", 32'(cfg_err), 1);
    check_eq("err_len_busy", 32'(busy), 0);
    run(20, 1, 0, 1);
    check_eq("err_no_trigger", rises.size(), 0);
    check_eq("err_one_cycle", err_cnt, 0);
    check_eq("err_shot_hold", 32'(shot_cnt), 2);
    check_eq("err_missed_hold", 32'(missed_cnt), 1);

    // Abort after 40 pulse cycles.
    start_burst(0, 100, 1);
    run(43, 1, 0, 1);
    check_eq("abort_rise_at", rises[0], 4);
    check_eq("abort_high_before", high_cnt, 40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_trigger", 32'(output_trigger), 0);
    check_eq("abort_busy", 32'(busy), 0);
    run(10, 1, 0, 0);
    check_eq("abort_no_done", dones.size(), 0);
    check_eq("abort_shot_hold", 32'(shot_cnt), 0);
    start_burst(2, 3, 1);
    check_eq("abort_restart_busy", 32'(busy), 1);
    run(15, 1, 0, 1);
    check_eq("abort_restart_rise", rises[0], 6);
    check_eq("abort_restart_done", dones[0], 9);
    check_eq("abort_restart_shot", 32'(shot_cnt), 1);

    // Asynchronous reset mid-DELAY takes effect without a clock edge.
    start_burst(50, 5, 1);
    run(20, 1, 0, 1);
    check_eq("rstmid_busy_before", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check_eq("rstmid_busy", 32'(busy), 0);
    check_eq("rstmid_trigger", 32'(output_trigger), 0);
    check_eq("rstmid_shot_cnt", 32'(shot_cnt), 0);
    tick();
    reset = 1'b1;
    tick();

    // WAIT_FG with no fg at all.
    start_burst(0, 1, 1);
    to_at = 0;
`ifdef SYNC_TIMEOUT_EN
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (timeout && to_at == 0) to_at = i;
    end
    check_eq("timeout_at", to_at, 100);
    check_eq("timeout_busy", 32'(busy), 0);
    check_eq("timeout_one_cycle", 32'(timeout), 0);
`else
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (timeout && to_at == 0) to_at = i;
    end
    check_eq("no_timeout_busy", 32'(busy), 1);
    check_eq("no_timeout_pulse", to_at, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("no_timeout_abort_busy", 32'(busy), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_burst_sequencer.md
Name: sync_burst_sequencer

Overview:
- Sequences a burst of N frame-grabber-synchronised triggers for the synchronization block.
- Armed by a start edge. For each shot it waits for an fg_signal edge, waits a programmable delay, then drives a programmable-length trigger pulse. It re-arms until N shots are done.
- Runtime-configurable replacement for the fixed single-shot trigger FSM. Sits between the host control registers and the camera/laser trigger output.

Parameters:
- CNT_W, 32, width of the delay/length counters and of cfg_delay/cfg_len.
- SHOT_W, 16, width of cfg_shots, shot_cnt and missed_cnt.
- TIMEOUT_CYCLES, 50_000_000, maximum WAIT_FG dwell before abort; used only with SYNC_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_signal  in  1  level input; its rising edge requests a burst. Synchronous to clock.
- fg_signal  in  1  frame-grabber opto signal; asynchronous, synchronised internally.
- abort  in  1  synchronous, active-high; cancels any burst.
- cfg_delay  in  CNT_W  cycles from fg edge to trigger.
- cfg_len  in  CNT_W  trigger high time in cycles; must be ≥1.
- cfg_shots  in  SHOT_W  shots per burst; must be ≥1.
- output_trigger  out  1  registered trigger output.
- busy  out  1  high from burst accept until DONE/abort/timeout.
- done  out  1  one-cycle pulse when the final shot's pulse ends.
- cfg_err  out  1  one-cycle pulse when a start is rejected.
- timeout  out  1  one-cycle pulse on WAIT_FG timeout; constant 0 without the macro.
- shot_cnt  out  SHOT_W  shots completed in the current or last burst.
- missed_cnt  out  SHOT_W  fg edges ignored during DELAY/PULSE; saturates at all-ones.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE. All outputs 0, all counters 0, synchroniser flops 0.
- fg path: 3 flops, sync1→sync2→sync3. fg_edge = sync2 & ~sync3.
- start_edge = start_signal & ~start_q, with start_q a 1-flop delay.
- States: IDLE, WAIT_FG, DELAY, PULSE, DONE.
- IDLE, on start_edge:
  - If cfg_shots==0 or cfg_len==0: pulse cfg_err, stay IDLE, leave shot_cnt/missed_cnt unchanged.
  - Otherwise: latch cfg_delay/cfg_len/cfg_shots into delay_q/len_q/shots_q, clear shot_cnt and missed_cnt, busy←1, go to WAIT_FG.
- Config inputs are ignored outside the accept cycle. start_edge while busy is ignored.
- WAIT_FG: on fg_edge, go to DELAY with cnt←0.
- DELAY:
  - If cnt==delay_q: go to PULSE, cnt←0, output_trigger←1.
  - Else cnt←cnt+1.
- Latency: if fg_signal is first sampled high at edge k, output_trigger rises at edge k+3+delay_q (delay_q=0 gives k+3).
- PULSE: output_trigger stays high for exactly len_q cycles. When cnt==len_q-1: output_trigger←0 and shot_cnt←shot_cnt+1.
  - If the new shot_cnt==shots_q, go to DONE.
  - Else return to WAIT_FG.
- fg_edge during DELAY or PULSE does not start a shot and increments missed_cnt (saturating).
- fg_edge in the same cycle as the PULSE→WAIT_FG transition counts as missed. Re-arming needs a fresh edge.
- DONE: lasts one cycle; done=1, busy←0, then IDLE.
- abort has priority over every state and over start_edge: next edge state=IDLE, output_trigger=0, busy=0, no done pulse. shot_cnt and missed_cnt hold their values.
- Counters never wrap. delay_q=2^CNT_W-1 is legal; the comparison is equality-based.
- busy and output_trigger are registered. No combinational path from any input to any output.

Optional Feature:
- Macro: SYNC_TIMEOUT_EN.
- Defined: a wait counter clears on WAIT_FG entry and increments each WAIT_FG cycle. When it reaches TIMEOUT_CYCLES-1 with no fg_edge: pulse timeout, busy←0, go to IDLE. fg_edge in that same cycle wins and the burst continues.
- Undefined: no wait counter is built; WAIT_FG waits indefinitely; timeout is tied to 0.

Test Plan:
- Single shot: cfg_delay=10, cfg_len=5, cfg_shots=1, start pulse, fg rises at edge k → trigger high at edges k+13..k+17 (5 cycles), done pulse one cycle after the trigger falls, shot_cnt=1, busy low after done.
- Burst: cfg_shots=3, cfg_delay=0, cfg_len=2, three fg pulses 20 cycles apart → three 2-cycle triggers each at fg+3, one done after the third, shot_cnt=3, missed_cnt=0.
- Overrun: cfg_delay=50, second fg edge 10 cycles after the first → one trigger only for the pair, missed_cnt=1, sequencer still waits for the next fg.
- Config error: cfg_shots=0 (then cfg_len=0) with start → cfg_err one cycle each time, busy stays 0, no trigger.
- Abort mid-pulse: cfg_len=100, abort at pulse cycle 40 → output_trigger and busy 0 on the next edge, no done, shot_cnt unchanged; a new start is then accepted normally. Also assert reset low mid-DELAY → all outputs 0 immediately.
- Timeout (SYNC_TIMEOUT_EN, TIMEOUT_CYCLES=100): start with no fg → timeout pulse 100 cycles after WAIT_FG entry, busy 0. Without the macro → busy remains 1 after 1000 cycles.
